stream_to_matrix: RTL and testbench
===================================

STREAM_TO_MATRIX -- requirements
Module: stream_to_matrix

Interface
REQ-001 Parameter DATA_W, default 32, element width in bits.
REQ-002 Parameter MAX_ROWS, default 32, maximum matrix rows (power of two, >=2).
REQ-003 Parameter MAX_COLS, default 32, maximum matrix columns (power of two, >=2).
REQ-004 Parameter ROW_W, default 5, equals log2(MAX_ROWS); COL_W, default 5, equals log2(MAX_COLS).
REQ-005 clock  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle request to begin a fill.
REQ-008 size_rows  in  ROW_W+1  row count for this fill, legal 1..MAX_ROWS.
REQ-009 size_cols  in  COL_W+1  column count for this fill, legal 1..MAX_COLS.
REQ-010 col_major  in  1  0: fill row-major; 1: fill column-major.
REQ-011 in_data  in  DATA_W  streamed element.
REQ-012 in_valid  in  1  in_data valid.
REQ-013 in_ready  out  1  block accepts in_data this cycle.
REQ-014 rd_row  in  ROW_W, rd_col  in  COL_W  read address.
REQ-015 rd_data  out  DATA_W  element at registered read address.
REQ-016 busy  out  1  fill in progress.
REQ-017 done  out  1  matrix complete; level.
REQ-018 err  out  1  one-cycle pulse: start rejected for illegal size.
REQ-019 elem_count  out  ROW_W+COL_W+1  elements accepted in current/last fill.

Function
REQ-020 FSM states IDLE, FILL, DONE; transfer occurs on cycle with in_valid=1 and in_ready=1.
REQ-021 IDLE or DONE + start + legal sizes -> FILL next cycle; size_rows, size_cols, col_major latched; row/col counters and elem_count cleared to 0; done cleared.
REQ-022 IDLE or DONE + start + size 0 or above MAX -> err=1 next cycle, state becomes IDLE, done cleared, no latch.
REQ-023 start in FILL ignored; latched sizes and mode frozen for whole fill.
REQ-024 in_ready=1 exactly when state is FILL (combinational from state); in_data ignored otherwise.
REQ-025 Each transfer writes in_data to storage[row][col] and increments elem_count.
REQ-026 Row-major: col increments; at col=size_cols-1 col wraps to 0 and row increments.
REQ-027 Column-major: row increments; at row=size_rows-1 row wraps to 0 and col increments.
REQ-028 Transfer of element size_rows*size_cols moves FILL -> DONE; done=1 and busy=0 from next cycle; in_ready=0 from next cycle.
REQ-029 busy=1 exactly in FILL; done=1 exactly in DONE.
REQ-030 1x1 matrix: single transfer completes fill; no zero-length fill exists.
REQ-031 Read port: rd_data registered, one-cycle latency from rd_row/rd_col, usable in any state.
REQ-032 Read and write same cell same cycle: rd_data returns previous contents.
REQ-033 Read of cell outside latched size or not written in current fill: contents undefined, no side effect.
REQ-034 Storage is MAX_ROWS x MAX_COLS x DATA_W, inferable as RAM, not cleared by reset or start.
REQ-035 Gaps in in_valid stall counters; no element lost or duplicated.

Reset
REQ-036 reset=1 -> next cycle state IDLE, in_ready=0, busy=0, done=0, err=0, elem_count=0, rd_data=0.
REQ-037 reset overrides start and transfers in same cycle; reset mid-fill aborts fill, storage contents retained but undefined for next fill.

Verification
REQ-038 start rows=2 cols=3 row-major, stream 1..6 continuous -> done after 6th transfer, storage[1][0]=4, elem_count=6.
REQ-039 Same stream col_major=1 -> storage[0][1]=3, storage[1][2]=6, done after 6 transfers.
REQ-040 rows=32 cols=32, in_valid toggling 1/0 -> exactly 1024 transfers, storage[31][31]=last word, done=1.
REQ-041 start with size_rows=0, then size_cols=33 -> err pulse each, state IDLE, in_ready=0.
REQ-042 reset after 3 of 6 transfers -> outputs at reset values next cycle; new start 1x1 with 0xA5 -> done after 1 transfer, rd_data=0xA5 one cycle after address 0,0.
REQ-043 start asserted during FILL -> ignored; new start in DONE restarts fill with elem_count=0.

Source files
------------

// File: rtl/stream_to_matrix.sv
// Streams elements into a MAX_ROWS x MAX_COLS matrix buffer, row- or column-major,
// with a registered random-access read port.
module stream_to_matrix #(
  parameter int DATA_W   = 32,
  parameter int MAX_ROWS = 32,
  parameter int MAX_COLS = 32,
  parameter int ROW_W    = 5,
  parameter int COL_W    = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ROW_W:0]           size_rows,
  input  logic [COL_W:0]           size_cols,
  input  logic                     col_major,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ROW_W-1:0]         rd_row,
  input  logic [COL_W-1:0]         rd_col,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [ROW_W+COL_W:0]     elem_count
);

  localparam int RS_W = ROW_W + 1;
  localparam int CS_W = COL_W + 1;
  localparam logic [RS_W-1:0] MAX_R = RS_W'(MAX_ROWS);
  localparam logic [CS_W-1:0] MAX_C = CS_W'(MAX_COLS);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t            state;
  logic [RS_W-1:0]   rows_q;
  logic [CS_W-1:0]   cols_q;
  logic              col_major_q;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic              xfer;
  logic              size_ok;
  logic              row_last;
  logic              col_last;

  logic [DATA_W-1:0] mem [MAX_ROWS*MAX_COLS];

  assign in_ready = (state == FILL);
  assign busy     = (state == FILL);
  assign done     = (state == DONE);
  assign xfer     = in_ready & in_valid;

  assign size_ok  = (size_rows != '0) && (size_rows <= MAX_R) &&
                    (size_cols != '0) && (size_cols <= MAX_C);

  // The final element is always at (rows-1, cols-1) regardless of fill order.
  assign row_last = ({1'b0, row} == (rows_q - RS_W'(1)));
  assign col_last = ({1'b0, col} == (cols_q - CS_W'(1)));

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      rows_q      <= '0;
      cols_q      <= '0;
      col_major_q <= 1'b0;
      row         <= '0;
      col         <= '0;
      elem_count  <= '0;
      err         <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (size_ok) begin
              state       <= FILL;
              rows_q      <= size_rows;
              cols_q      <= size_cols;
              col_major_q <= col_major;
              row         <= '0;
              col         <= '0;
              elem_count  <= '0;
            end else begin
              state <= IDLE;
              err   <= 1'b1;
            end
          end
        end
        FILL: begin
          if (xfer) begin
            elem_count <= elem_count + 1'b1;
            if (row_last && col_last)
              state <= DONE;
            if (col_major_q) begin
              if (row_last) begin
                row <= '0;
                col <= col + 1'b1;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              if (col_last) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is kept free of reset so it maps onto block RAM.
  always_ff @(posedge clock) begin
    if (xfer)
      mem[{row, col}] <= in_data;
  end

  always_ff @(posedge clock) begin
    if (reset)
      rd_data <= '0;
    else
      rd_data <= mem[{rd_row, rd_col}];
  end

endmodule

// File: tb/tb_stream_to_matrix.sv
// Directed self-checking bench for stream_to_matrix using default 32x32 geometry.
module tb_stream_to_matrix;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  size_rows;
  logic [5:0]  size_cols;
  logic        col_major;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rd_row;
  logic [4:0]  rd_col;
  logic [31:0] rd_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [10:0] elem_count;

  int checks = 0;
  int errors = 0;

  stream_to_matrix #(.DATA_W(32), .MAX_ROWS(32), .MAX_COLS(32), .ROW_W(5), .COL_W(5)) dut (
    .clock(clock), .reset(reset), .start(start), .size_rows(size_rows), .size_cols(size_cols),
    .col_major(col_major), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data), .busy(busy), .done(done),
    .err(err), .elem_count(elem_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [5:0] r, input logic [5:0] c, input logic cm);
    start = 1'b1; size_rows = r; size_cols = c; col_major = cm;
    tick();
    start = 1'b0;
  endtask

  task automatic stream(input logic [31:0] first, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      in_data  = first + 32'(i);
      in_valid = 1'b1;
      tick();
      if (gap) begin
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
        tick();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic rd(input logic [4:0] r, input logic [4:0] c, input logic [31:0] exp, input string tag);
    rd_row = r; rd_col = c;
    tick();
    check(tag, 64'(rd_data), 64'(exp));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; size_rows = '0; size_cols = '0; col_major = 1'b0;
    in_data = '0; in_valid = 1'b0; rd_row = '0; rd_col = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_count", 64'(elem_count), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);

    // 2x3 row-major, 1..6
    do_start(6'd2, 6'd3, 1'b0);
    check("rm_busy", 64'(busy), 64'd1);
    check("rm_ready", 64'(in_ready), 64'd1);
    check("rm_count0", 64'(elem_count), 64'd0);
    stream(32'd1, 5, 1'b0);
    check("rm_not_done_5", 64'(done), 64'd0);
    check("rm_count5", 64'(elem_count), 64'd5);
    stream(32'd6, 1, 1'b0);
    check("rm_done", 64'(done), 64'd1);
    check("rm_busy_off", 64'(busy), 64'd0);
    check("rm_ready_off", 64'(in_ready), 64'd0);
    check("rm_count6", 64'(elem_count), 64'd6);
    in_data = 32'd99; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("rm_done_ignores_data", 64'(elem_count), 64'd6);
    rd(5'd1, 5'd0, 32'd4, "rm_s10");
    rd(5'd0, 5'd1, 32'd2, "rm_s01");
    rd(5'd1, 5'd2, 32'd6, "rm_s12");

    // 2x3 column-major restart from DONE, with an ignored start mid-fill
    do_start(6'd2, 6'd3, 1'b1);
    check("cm_count_cleared", 64'(elem_count), 64'd0);
    check("cm_done_cleared", 64'(done), 64'd0);
    stream(32'd1, 2, 1'b0);
    do_start(6'd1, 6'd1, 1'b0);
    check("cm_start_ignored_busy", 64'(busy), 64'd1);
    check("cm_start_ignored_count", 64'(elem_count), 64'd2);
    stream(32'd3, 4, 1'b0);
    check("cm_done", 64'(done), 64'd1);
    check("cm_count6", 64'(elem_count), 64'd6);
    rd(5'd0, 5'd1, 32'd3, "cm_s01");
    rd(5'd1, 5'd2, 32'd6, "cm_s12");
    rd(5'd1, 5'd0, 32'd2, "cm_s10");

    // Illegal sizes
    do_start(6'd0, 6'd3, 1'b0);
    check("err_rows0", 64'(err), 64'd1);
    check("err_rows0_done", 64'(done), 64'd0);
    check("err_rows0_ready", 64'(in_ready), 64'd0);
    tick();
    check("err_pulse_clears", 64'(err), 64'd0);
    do_start(6'd2, 6'd33, 1'b0);
    check("err_cols33", 64'(err), 64'd1);
    check("err_cols33_busy", 64'(busy), 64'd0);
    check("err_cols33_ready", 64'(in_ready), 64'd0);

    // 32x32 with in_valid toggling
    do_start(6'd32, 6'd32, 1'b0);
    check("big_busy", 64'(busy), 64'd1);
    stream(32'h1000, 1023, 1'b1);
    check("big_count1023", 64'(elem_count), 64'd1023);
    check("big_not_done", 64'(done), 64'd0);
    stream(32'h1000 + 32'd1023, 1, 1'b1);
    check("big_done", 64'(done), 64'd1);
    check("big_count1024", 64'(elem_count), 64'd1024);
    rd(5'd31, 5'd31, 32'h1000 + 32'd1023, "big_s3131");
    rd(5'd0, 5'd0, 32'h1000, "big_s00");
    rd(5'd0, 5'd31, 32'h1000 + 32'd31, "big_s0031");
    rd(5'd1, 5'd0, 32'h1000 + 32'd32, "big_s0100");

    // Reset mid-fill, then 1x1 with read-before-write on the same cell
    do_start(6'd2, 6'd3, 1'b0);
    stream(32'h21, 3, 1'b0);
    check("abort_count3", 64'(elem_count), 64'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ready", 64'(in_ready), 64'd0);
    check("abort_count", 64'(elem_count), 64'd0);
    check("abort_rd_data", 64'(rd_data), 64'd0);
    rd_row = 5'd0; rd_col = 5'd0;
    do_start(6'd1, 6'd1, 1'b0);
    check("one_busy", 64'(busy), 64'd1);
    stream(32'hA5, 1, 1'b0);
    check("one_rdw_old", 64'(rd_data), 64'h21);
    check("one_done", 64'(done), 64'd1);
    check("one_count", 64'(elem_count), 64'd1);
    check("one_ready_off", 64'(in_ready), 64'd0);
    tick();
    check("one_rd_a5", 64'(rd_data), 64'hA5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
